// File: rtl/shift_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_universal
//  Purpose  : WIDTH-bit universal shift register with clock enable. It can
//             hold, load, shift or rotate in either direction, and clear.
//             A shift counter raises a one-cycle word_done strobe after
//             every WIDTH shift or rotate operations.
//  Revision : 1.0  initial release
// ============================================================================
module shift_reg_universal #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in_left,
  input  logic             ser_in_right,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic [CW-1:0]    shift_count,
  output logic             word_done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;

  // The count value at which the next shift op wraps and fires word_done.
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;
  logic [WIDTH-1:0] next_data;
  logic             shift_op;
  logic             restart;

  // A one-bit register has no interior bits to move: shifts take the serial
  // input directly and rotates leave the bit where it is.
  generate
    if (WIDTH == 1) begin : g_single_bit
      assign shl_val = ser_in_right;
      assign shr_val = ser_in_left;
      assign rol_val = data_out;
      assign ror_val = data_out;
    end else begin : g_multi_bit
      assign shl_val = {data_out[WIDTH-2:0], ser_in_right};
      assign shr_val = {ser_in_left, data_out[WIDTH-1:1]};
      assign rol_val = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
      assign ror_val = {data_out[0], data_out[WIDTH-1:1]};
    end
  endgenerate

  assign ser_out_msb = data_out[WIDTH-1];
  assign ser_out_lsb = data_out[0];

  // Mode decode: next register value and whether this edge counts as a shift
  // op or restarts the count. Hold and the reserved code fall to the default.
  always_comb begin
    next_data = data_out;
    shift_op  = 1'b0;
    restart   = 1'b0;
    if (en) begin
      case (mode)
        MODE_LOAD: begin
          next_data = data_in;
          restart   = 1'b1;
        end
        MODE_SHL: begin
          next_data = shl_val;
          shift_op  = 1'b1;
        end
        MODE_SHR: begin
          next_data = shr_val;
          shift_op  = 1'b1;
        end
        MODE_ROL: begin
          next_data = rol_val;
          shift_op  = 1'b1;
        end
        MODE_ROR: begin
          next_data = ror_val;
          shift_op  = 1'b1;
        end
        MODE_CLEAR: begin
          next_data = RESET_VALUE;
          restart   = 1'b1;
        end
        default: begin
          next_data = data_out;
        end
      endcase
    end
  end

  // Register bank, shift counter and word_done strobe. The strobe is cleared
  // on every edge that is not a wrapping shift op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out    <= RESET_VALUE;
      shift_count <= '0;
      word_done   <= 1'b0;
    end else begin
      data_out <= next_data;
      if (restart) begin
        shift_count <= '0;
        word_done   <= 1'b0;
      end else if (shift_op) begin
        if (shift_count == LAST_COUNT) begin
          shift_count <= '0;
          word_done   <= 1'b1;
        end else begin
          shift_count <= shift_count + CW'(1);
          word_done   <= 1'b0;
        end
      end else begin
        word_done <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_reg_universal
//  Purpose  : Self-checking bench for shift_reg_universal (WIDTH=8 and WIDTH=1)
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_reg_universal;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_CLEAR = 3'b110;
  localparam logic [2:0] M_RSVD  = 3'b111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] data_in;
  logic       ser_in_left;
  logic       ser_in_right;

  logic [7:0] data_out;
  logic       ser_out_msb;
  logic       ser_out_lsb;
  logic [3:0] shift_count;
  logic       word_done;

  logic [0:0] d1_out;
  logic       d1_msb;
  logic       d1_lsb;
  logic [0:0] d1_cnt;
  logic       d1_wd;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: register value as an integer, shift ops since
  // the last restart, and the expected strobe.
  int m_data, m_ops, m_wd;
  int m1_data, m1_wd;

  shift_reg_universal #(.WIDTH(8), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .data_in(data_in),
    .ser_in_left(ser_in_left), .ser_in_right(ser_in_right),
    .data_out(data_out), .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb),
    .shift_count(shift_count), .word_done(word_done)
  );

  shift_reg_universal #(.WIDTH(1), .RESET_VALUE(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .data_in(data_in[0:0]),
    .ser_in_left(ser_in_left), .ser_in_right(ser_in_right),
    .data_out(d1_out), .ser_out_msb(d1_msb), .ser_out_lsb(d1_lsb),
    .shift_count(d1_cnt), .word_done(d1_wd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Drive one operation, clock it, advance the model, sample 1 time unit later.
  task automatic do_op(input logic e, input logic [2:0] md, input logic [7:0] din,
                       input logic l, input logic r);
    bit shift;
    en = e; mode = md; data_in = din; ser_in_left = l; ser_in_right = r;
    @(posedge clk);
    shift = 1'b0;
    m_wd  = 0;
    m1_wd = 0;
    if (e) begin
      case (md)
        M_LOAD:  begin m_data = din; m_ops = 0; m1_data = din % 2; end
        M_SHL:   begin m_data = (m_data * 2 + r) % 256; m1_data = r; shift = 1'b1; end
        M_SHR:   begin m_data = m_data / 2 + l * 128;   m1_data = l; shift = 1'b1; end
        M_ROL:   begin m_data = (m_data * 2) % 256 + m_data / 128; shift = 1'b1; end
        M_ROR:   begin m_data = m_data / 2 + (m_data % 2) * 128;   shift = 1'b1; end
        M_CLEAR: begin m_data = RV; m_ops = 0; m1_data = 1; end
        default: ;
      endcase
    end
    if (shift) begin
      m_ops = m_ops + 1;
      if (m_ops == W) begin
        m_ops = 0;
        m_wd  = 1;
      end
      m1_wd = 1;
    end
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic apply_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    m_data = RV; m_ops = 0; m_wd = 0;
    m1_data = 1; m1_wd = 0;
  endtask

  task automatic test_reset();
    do_op(1'b1, M_LOAD, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) do_op(1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
    n_total++;
    if (word_done !== 1'b1 || data_out !== 8'hFF)
      $display("FAIL pre_reset_state: got data=%h wd=%b expected data=ff wd=1", data_out, word_done);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (data_out !== RV) $display("FAIL reset_data_async: got %h expected %h", data_out, RV);
    else n_pass++;
    n_total++;
    if (shift_count !== 4'd0) $display("FAIL reset_count_async: got %0d expected 0", shift_count);
    else n_pass++;
    n_total++;
    if (word_done !== 1'b0) $display("FAIL reset_wd_async: got %b expected 0", word_done);
    else n_pass++;
    n_total++;
    if (d1_out !== 1'b1) $display("FAIL reset_w1_data: got %b expected 1", d1_out);
    else n_pass++;
    en = 1'b1; mode = M_SHL; ser_in_right = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if (data_out !== RV) $display("FAIL reset_held_over_edge: got %h expected %h", data_out, RV);
    else n_pass++;
    #1;
    reset_n = 1'b1;
    m_data = RV; m_ops = 0; m_wd = 0; m1_data = 1; m1_wd = 0;
    do_op(1'b1, M_HOLD, 8'h00, 1'b0, 1'b0);
    n_total++;
    if (data_out !== RV || shift_count !== 4'd0)
      $display("FAIL reset_release: got data=%h cnt=%0d expected data=%h cnt=0", data_out, shift_count, RV);
    else n_pass++;
  endtask

  task automatic test_load_shl();
    do_op(1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
    do_op(1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
    n_total++;
    if (data_out !== 8'h03) $display("FAIL shl_data: got %h expected 03", data_out);
    else n_pass++;
    n_total++;
    if (shift_count !== 4'd1) $display("FAIL shl_count: got %0d expected 1", shift_count);
    else n_pass++;
    n_total++;
    if (ser_out_msb !== 1'b0 || ser_out_lsb !== 1'b1)
      $display("FAIL shl_serial_out: got msb=%b lsb=%b expected msb=0 lsb=1", ser_out_msb, ser_out_lsb);
    else n_pass++;
  endtask

  task automatic test_serialise();
    logic [7:0] lsb_seq = 8'hC3;
    do_op(1'b1, M_LOAD, 8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (ser_out_lsb !== lsb_seq[i])
        $display("FAIL ror_lsb_seq[%0d]: got %b expected %b", i, ser_out_lsb, lsb_seq[i]);
      else n_pass++;
      n_total++;
      if (word_done !== 1'b0) $display("FAIL ror_wd_early[%0d]: got %b expected 0", i, word_done);
      else n_pass++;
      do_op(1'b1, M_ROR, 8'h00, 1'b1, 1'b1);
    end
    n_total++;
    if (data_out !== 8'hC3 || word_done !== 1'b1 || shift_count !== 4'd0)
      $display("FAIL ror_wrap: got data=%h wd=%b cnt=%0d expected data=c3 wd=1 cnt=0",
               data_out, word_done, shift_count);
    else n_pass++;
    do_op(1'b1, M_HOLD, 8'h00, 1'b0, 1'b0);
    n_total++;
    if (word_done !== 1'b0) $display("FAIL ror_wd_one_cycle: got %b expected 0", word_done);
    else n_pass++;
  endtask

  task automatic test_deserialise();
    logic [7:0] bits = 8'h4D;
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      do_op(1'b1, M_SHR, 8'h00, bits[i], 1'b0);
      if (word_done === 1'b1) pulses++;
    end
    n_total++;
    if (data_out !== 8'h4D) $display("FAIL shr_data: got %h expected 4d", data_out);
    else n_pass++;
    n_total++;
    if (word_done !== 1'b1 || pulses != 1)
      $display("FAIL shr_wd: got wd=%b pulses=%0d expected wd=1 pulses=1", word_done, pulses);
    else n_pass++;
  endtask

  task automatic test_enable();
    do_op(1'b1, M_LOAD, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_op(1'b0, M_SHL, 8'h00, 1'b1, 1'b1);
    n_total++;
    if (data_out !== 8'h3C || shift_count !== 4'd0 || word_done !== 1'b0)
      $display("FAIL en_gate: got data=%h cnt=%0d wd=%b expected data=3c cnt=0 wd=0",
               data_out, shift_count, word_done);
    else n_pass++;
    do_op(1'b1, M_RSVD, 8'hFF, 1'b1, 1'b1);
    n_total++;
    if (data_out !== 8'h3C || shift_count !== 4'd0)
      $display("FAIL reserved_mode: got data=%h cnt=%0d expected data=3c cnt=0", data_out, shift_count);
    else n_pass++;
    do_op(1'b1, M_ROL, 8'h00, 1'b0, 1'b0);
    do_op(1'b0, M_CLEAR, 8'h00, 1'b0, 1'b0);
    do_op(1'b1, M_RSVD, 8'h00, 1'b0, 1'b0);
    n_total++;
    if (data_out !== 8'h78 || shift_count !== 4'd1)
      $display("FAIL gate_nonzero_count: got data=%h cnt=%0d expected data=78 cnt=1", data_out, shift_count);
    else n_pass++;
  endtask

  task automatic test_interrupted();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) do_op(1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
      if (pass == 0) do_op(1'b1, M_CLEAR, 8'h00, 1'b0, 1'b0);
      else apply_reset();
      for (int i = 0; i < 8; i++) begin
        do_op(1'b1, M_SHL, 8'h00, 1'b0, 1'b0);
        n_total++;
        if (word_done !== (i == 7) || shift_count !== 4'((i + 1) % 8))
          $display("FAIL interrupted_%0d[%0d]: got wd=%b cnt=%0d expected wd=%b cnt=%0d",
                   pass, i, word_done, shift_count, (i == 7), (i + 1) % 8);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [14:0] exp8;
    logic [4:0]  exp1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) apply_reset();
      do_op(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom), 1'($urandom));
      exp8 = {m_data[7:0], m_ops[3:0], m_wd[0], m_data[7], m_data[0]};
      exp1 = {m1_data[0], 1'b0, m1_wd[0], m1_data[0], m1_data[0]};
      n_total++;
      if ({data_out, shift_count, word_done, ser_out_msb, ser_out_lsb} !== exp8)
        $display("FAIL random_w8[%0d]: got data=%h cnt=%0d wd=%b expected data=%h cnt=%0d wd=%0d",
                 i, data_out, shift_count, word_done, m_data[7:0], m_ops, m_wd);
      else n_pass++;
      n_total++;
      if ({d1_out, d1_cnt, d1_wd, d1_msb, d1_lsb} !== exp1)
        $display("FAIL random_w1[%0d]: got data=%b cnt=%0d wd=%b expected data=%0d cnt=0 wd=%0d",
                 i, d1_out, d1_cnt, d1_wd, m1_data, m1_wd);
      else n_pass++;
    end
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; mode = M_HOLD; data_in = 8'h00;
    ser_in_left = 1'b0; ser_in_right = 1'b0;
    m_data = RV; m_ops = 0; m_wd = 0; m1_data = 1; m1_wd = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_load_shl();
    test_serialise();
    test_deserialise();
    test_enable();
    test_interrupted();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank with a clock enable and eight operating modes.
- Modes are hold, parallel load, logical shift left/right with serial inputs, rotate left/right, clear, and a reserved code.
- A shift counter tracks shift/rotate operations and raises a one-cycle word_done strobe after every WIDTH of them.
- Used as the serialiser/deserialiser and general storage stage in the flip-flop chapter designs.

Parameters:
WIDTH, 8, register width in bits, legal range 1..64
RESET_VALUE, 0, value loaded into data_out on reset and on the clear mode; WIDTH bits
CW, $clog2(WIDTH+1), width of shift_count; derived, not overridden

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
en  input  1  clock enable; 0 freezes all state
mode  input  3  operation select, sampled on the rising edge of clk
data_in  input  WIDTH  parallel load value
ser_in_left  input  1  bit shifted into the MSB on shift right
ser_in_right  input  1  bit shifted into the LSB on shift left
data_out  output  WIDTH  register contents
ser_out_msb  output  1  data_out[WIDTH-1], combinational from the register
ser_out_lsb  output  1  data_out[0], combinational from the register
shift_count  output  CW  shift/rotate ops since the last load, clear, wrap or reset
word_done  output  1  registered one-cycle strobe when shift_count wraps

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset_n=0, asynchronous assert):
  - data_out=RESET_VALUE, shift_count=0, word_done=0 immediately, independent of clk.
  - Deassertion takes effect at the next rising edge of clk.
- All state updates occur on the rising edge of clk. Latency is one cycle: the result of the mode sampled at edge N is visible after edge N.
- en=0:
  - data_out and shift_count hold.
  - word_done=0.
  - mode is ignored.
- en=1, mode decode:
  - 000 hold: no change; word_done=0.
  - 001 load: data_out<=data_in; shift_count<=0; word_done<=0.
  - 010 shl: data_out<={data_out[W-2:0], ser_in_right}. Shift op.
  - 011 shr: data_out<={ser_in_left, data_out[W-1:1]}. Shift op.
  - 100 rol: data_out<={data_out[W-2:0], data_out[W-1]}. Shift op.
  - 101 ror: data_out<={data_out[0], data_out[W-1:1]}. Shift op.
  - 110 clear: data_out<=RESET_VALUE; shift_count<=0; word_done<=0.
  - 111 reserved: behaves exactly as hold.
- WIDTH=1 degenerate cases:
  - shl: data_out<=ser_in_right.
  - shr: data_out<=ser_in_left.
  - rol/ror: data_out holds its value.
  - Every shift op wraps the counter and pulses word_done.
- Shift-op counter rules:
  - shift_count /= WIDTH-1: shift_count<=shift_count+1; word_done<=0.
  - shift_count == WIDTH-1: shift_count<=0; word_done<=1 for exactly the following cycle.
- Any non-shift mode, or en=0, drives word_done to 0 on that edge. Back-to-back wraps are only possible for WIDTH=1; there word_done stays high on consecutive cycles.
- shift_count never exceeds WIDTH-1 and never shows the value WIDTH.
- Reset mid-sequence discards the partial count. The next WIDTH shift ops are required before word_done fires again.
- Load or clear mid-sequence restarts the count from 0.
- Serial-in bits are sampled at the same edge as mode. The serial-in bit not used by the current mode is ignored.

Test Plan:
1. Reset with WIDTH=8, RESET_VALUE=8'hA5: drive reset_n=0 between clock edges -> data_out=8'hA5, shift_count=0, word_done=0 before the next edge.
2. Load then shl: load 8'h81, then shl with ser_in_right=1 -> data_out=8'h03, shift_count=1, ser_out_msb=0, ser_out_lsb=1.
3. Serialise: load 8'hC3, then 8 consecutive ror ops -> ser_out_lsb sequence 1,1,0,0,0,0,1,1; data_out=8'hC3 after the 8th op; word_done=1 for exactly one cycle after the 8th edge; shift_count=0.
4. Deserialise: 8 shr ops with ser_in_left sequence 1,0,1,1,0,0,1,0 -> data_out=8'h4D; word_done pulses once.
5. Enable gating: load 8'h3C, then shl with en=0 for 3 cycles -> data_out=8'h3C, shift_count unchanged, word_done=0. Mode 111 with en=1 -> no change.
6. Interrupted count: 5 shl ops, then clear, then 8 shl ops -> word_done fires only after the 8th post-clear op. Repeat with reset_n pulsed after 5 ops -> same result.
